// File: rtl/counter_arbiter.sv
// Two-requester round-robin arbiter that lends a shared loadable up counter to the winner,
// runs it from the winner's start value to its terminal value, then pulses that winner's done.
module counter_arbiter (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic       req1,
  input  logic [3:0] start0,
  input  logic [3:0] start1,
  input  logic [3:0] end0,
  input  logic [3:0] end1,
  input  logic [3:0] cnt_q,
  output logic       cnt_rst,
  output logic       cnt_load,
  output logic [3:0] cnt_din,
  output logic       gnt0,
  output logic       gnt1,
  output logic       done0,
  output logic       done1,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic       ptr_q, ptr_d;
  logic       win_q, win_d;
  logic [3:0] start_q, start_d;
  logic [3:0] end_q, end_d;
  logic       pick_s;
  logic       win_req_s;

  logic       cnt_rst_q, cnt_load_q, gnt0_q, gnt1_q, done0_q, done1_q, busy_q;
  logic [3:0] cnt_din_q;

  // Winner selection and the winner's own request level
  always_comb begin
    if (req0 && req1) begin
      pick_s = ptr_q;
    end else begin
      pick_s = req1;
    end
    win_req_s = win_q ? req1 : req0;
  end

  // Next-state logic; the pointer always moves to the non-winner when a grant ends
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    start_d = start_q;
    end_d   = end_q;
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          win_d   = pick_s;
          start_d = pick_s ? start1 : start0;
          end_d   = pick_s ? end1 : end0;
          state_d = LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      LOAD: begin
        if (!win_req_s) begin
          state_d = IDLE;
          ptr_d   = ~win_q;
        end else begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (!win_req_s) begin
          state_d = IDLE;
          ptr_d   = ~win_q;
        end else if (cnt_q == end_q) begin
          state_d = DONE;
        end else begin
          state_d = RUN;
        end
      end
      DONE: begin
        state_d = IDLE;
        ptr_d   = ~win_q;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers and registered Moore outputs decoded from the next state
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      ptr_q      <= 1'b0;
      win_q      <= 1'b0;
      start_q    <= 4'd0;
      end_q      <= 4'd0;
      cnt_rst_q  <= 1'b1;
      cnt_load_q <= 1'b0;
      cnt_din_q  <= 4'd0;
      gnt0_q     <= 1'b0;
      gnt1_q     <= 1'b0;
      done0_q    <= 1'b0;
      done1_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      win_q      <= win_d;
      start_q    <= start_d;
      end_q      <= end_d;
      cnt_rst_q  <= (state_d == IDLE) || (state_d == DONE);
      cnt_load_q <= (state_d == LOAD);
      cnt_din_q  <= (state_d == LOAD) ? start_d : 4'd0;
      gnt0_q     <= (state_d != IDLE) && !win_d;
      gnt1_q     <= (state_d != IDLE) && win_d;
      done0_q    <= (state_d == DONE) && !win_d;
      done1_q    <= (state_d == DONE) && win_d;
      busy_q     <= (state_d != IDLE);
    end
  end

  assign cnt_rst  = cnt_rst_q;
  assign cnt_load = cnt_load_q;
  assign cnt_din  = cnt_din_q;
  assign gnt0     = gnt0_q;
  assign gnt1     = gnt1_q;
  assign done0    = done0_q;
  assign done1    = done1_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_counter_arbiter.sv
// Bench for counter_arbiter: a directed vector table plus random traffic checked against
// a grant-timeline model (age since grant vs. computed run length).
module tb_counter_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       req0 = 1'b0, req1 = 1'b0;
  logic [3:0] start0 = 4'd0, start1 = 4'd0, end0 = 4'd0, end1 = 4'd0;
  logic [3:0] cnt_q = 4'd0;
  logic       cnt_rst, cnt_load, gnt0, gnt1, done0, done1, busy;
  logic [3:0] cnt_din;

  int n_chk = 0;
  int n_err = 0;

  counter_arbiter dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1),
    .start0(start0), .start1(start1), .end0(end0), .end1(end1),
    .cnt_q(cnt_q), .cnt_rst(cnt_rst), .cnt_load(cnt_load), .cnt_din(cnt_din),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1), .busy(busy)
  );

  always #5 clk = ~clk;

  // Shared counter the arbiter controls
  always @(posedge clk) begin
    if (cnt_rst) cnt_q <= 4'd0;
    else if (cnt_load) cnt_q <= cnt_din;
    else cnt_q <= cnt_q + 4'd1;
  end

  // Reference model: owner (-1 = none), cycles since grant, run length from arithmetic
  int         m_owner = -1;
  int         m_ptr = 0;
  int         m_age = 0;
  int         m_len = 0;
  logic [3:0] m_s = 4'd0;

  task automatic model_update();
    int w;
    logic [3:0] e;
    bit r;
    if (!rst) begin
      m_owner = -1;
      m_ptr   = 0;
    end else if (m_owner < 0) begin
      if (req0 || req1) begin
        w = (req0 && req1) ? m_ptr : (req1 ? 1 : 0);
        m_owner = w;
        m_s   = (w == 1) ? start1 : start0;
        e     = (w == 1) ? end1 : end0;
        m_len = ((int'(e) - int'(m_s) + 16) % 16) + 1;
        m_age = 0;
      end
    end else begin
      r = (m_owner == 1) ? req1 : req0;
      if ((m_age <= m_len && !r) || m_age == m_len + 1) begin
        m_ptr   = 1 - m_owner;
        m_owner = -1;
      end else begin
        m_age = m_age + 1;
      end
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic check_model();
    bit fin;
    fin = (m_owner >= 0) && (m_age == m_len + 1);
    chk("m_gnt0", gnt0, (m_owner == 0) ? 1 : 0);
    chk("m_gnt1", gnt1, (m_owner == 1) ? 1 : 0);
    chk("m_done0", done0, (fin && m_owner == 0) ? 1 : 0);
    chk("m_done1", done1, (fin && m_owner == 1) ? 1 : 0);
    chk("m_busy", busy, (m_owner >= 0) ? 1 : 0);
    chk("m_cnt_rst", cnt_rst, (m_owner < 0 || fin) ? 1 : 0);
    chk("m_cnt_load", cnt_load, (m_owner >= 0 && m_age == 0) ? 1 : 0);
    chk("m_cnt_din", cnt_din, (m_owner >= 0 && m_age == 0) ? int'(m_s) : 0);
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
    check_model();
  endtask

  typedef struct {
    bit rst, r0, r1;
    bit [3:0] s0, e0;
    bit g0, g1, d0, d1, bz, crst, ld;
    bit [3:0] din;
    bit ck;
    bit [3:0] cnt;
  } vec_t;

  vec_t tv[$];

  task automatic add(input bit rs, r0, r1, input bit [3:0] s0, e0,
                     input bit g0, g1, d0, d1, bz, crst, ld, input bit [3:0] din,
                     input bit ck, input bit [3:0] cnt);
    vec_t v;
    v.rst = rs; v.r0 = r0; v.r1 = r1; v.s0 = s0; v.e0 = e0;
    v.g0 = g0; v.g1 = g1; v.d0 = d0; v.d1 = d1; v.bz = bz; v.crst = crst; v.ld = ld;
    v.din = din; v.ck = ck; v.cnt = cnt;
    tv.push_back(v);
  endtask

  initial begin
    // rst ri ri s0 e0 | g0 g1 d0 d1 bz crst ld din | ck cnt
    add(0,1,1, 3,6, 0,0,0,0,0,1,0, 0, 0, 0);
    add(0,1,1, 3,6, 0,0,0,0,0,1,0, 0, 1, 0);
    add(1,1,1, 3,6, 1,0,0,0,1,0,1, 3, 1, 0);
    add(1,1,1, 3,6, 1,0,0,0,1,0,0, 0, 1, 3);
    add(1,1,1, 3,6, 1,0,0,0,1,0,0, 0, 1, 4);
    add(1,1,1, 3,6, 1,0,0,0,1,0,0, 0, 1, 5);
    add(1,1,1, 3,6, 1,0,0,0,1,0,0, 0, 1, 6);
    add(1,1,1, 3,6, 1,0,1,0,1,1,0, 0, 1, 7);
    add(1,0,1, 3,6, 0,0,0,0,0,1,0, 0, 1, 0);
    add(1,0,1, 3,6, 0,1,0,0,1,0,1,14, 1, 0);
    add(1,0,1, 3,6, 0,1,0,0,1,0,0, 0, 1,14);
    add(1,0,1, 3,6, 0,1,0,0,1,0,0, 0, 1,15);
    add(1,0,1, 3,6, 0,1,0,0,1,0,0, 0, 1, 0);
    add(1,0,1, 3,6, 0,1,0,0,1,0,0, 0, 1, 1);
    add(1,0,1, 3,6, 0,1,0,1,1,1,0, 0, 1, 2);
    add(1,0,0, 3,6, 0,0,0,0,0,1,0, 0, 1, 0);
    add(1,1,1, 9,9, 1,0,0,0,1,0,1, 9, 1, 0);
    add(1,1,1, 9,9, 1,0,0,0,1,0,0, 0, 1, 9);
    add(1,1,1, 9,9, 1,0,1,0,1,1,0, 0, 1,10);
    add(1,0,1, 9,9, 0,0,0,0,0,1,0, 0, 1, 0);
    add(1,0,1, 9,9, 0,1,0,0,1,0,1,14, 1, 0);
    add(1,0,0, 9,9, 0,0,0,0,0,1,0, 0, 1,14);
    add(1,1,0, 3,6, 1,0,0,0,1,0,1, 3, 1, 0);
    add(1,1,0, 3,6, 1,0,0,0,1,0,0, 0, 1, 3);
    add(1,1,0, 3,6, 1,0,0,0,1,0,0, 0, 1, 4);
    add(1,0,1, 3,6, 0,0,0,0,0,1,0, 0, 1, 5);
    add(1,1,1, 3,6, 0,1,0,0,1,0,1,14, 1, 0);
    add(1,1,1, 3,6, 0,1,0,0,1,0,0, 0, 1,14);
    add(0,1,1, 3,6, 0,0,0,0,0,1,0, 0, 1,15);
    add(1,1,1, 3,6, 1,0,0,0,1,0,1, 3, 1, 0);
    add(1,0,0, 3,6, 0,0,0,0,0,1,0, 0, 1, 3);

    start1 = 4'd14;
    end1   = 4'd1;
    @(negedge clk);
    for (int i = 0; i < tv.size(); i++) begin
      rst = tv[i].rst; req0 = tv[i].r0; req1 = tv[i].r1;
      start0 = tv[i].s0; end0 = tv[i].e0;
      step();
      chk($sformatf("v%0d_gnt0", i), gnt0, tv[i].g0);
      chk($sformatf("v%0d_gnt1", i), gnt1, tv[i].g1);
      chk($sformatf("v%0d_done0", i), done0, tv[i].d0);
      chk($sformatf("v%0d_done1", i), done1, tv[i].d1);
      chk($sformatf("v%0d_busy", i), busy, tv[i].bz);
      chk($sformatf("v%0d_cnt_rst", i), cnt_rst, tv[i].crst);
      chk($sformatf("v%0d_cnt_load", i), cnt_load, tv[i].ld);
      chk($sformatf("v%0d_cnt_din", i), cnt_din, tv[i].din);
      if (tv[i].ck) chk($sformatf("v%0d_cnt_q", i), cnt_q, tv[i].cnt);
    end

    // Random traffic: requests held until done, with occasional aborts, resets and operand churn
    for (int c = 0; c < 3000; c++) begin
      bit fin;
      fin = (m_owner >= 0) && (m_age == m_len + 1);
      rst = ($urandom_range(0, 99) != 0);
      if (req0) begin
        if (fin && m_owner == 0) req0 = ($urandom_range(0, 9) == 0);
        else req0 = ($urandom_range(0, 29) != 0);
      end else begin
        req0 = ($urandom_range(0, 4) == 0);
      end
      if (req1) begin
        if (fin && m_owner == 1) req1 = ($urandom_range(0, 9) == 0);
        else req1 = ($urandom_range(0, 29) != 0);
      end else begin
        req1 = ($urandom_range(0, 4) == 0);
      end
      if ($urandom_range(0, 3) == 0) begin
        start0 = 4'($urandom_range(0, 15));
        end0   = 4'($urandom_range(0, 15));
        start1 = 4'($urandom_range(0, 15));
        end1   = 4'($urandom_range(0, 15));
      end
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
